// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues in-order fetches against a credit limit and buffers responses
// in a small FIFO that feeds the decoder one {pc, word} entry per cycle.
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    output logic        protocol_err
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SumW = PtrW + 2;

    logic [63:0]     req_pc_q, req_pc_d;
    logic [63:0]     rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] occ_q, occ_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]     fifo_pc_q [DEPTH];
    logic [63:0]     fifo_pc_d [DEPTH];
    logic [31:0]     fifo_word_q [DEPTH];
    logic [31:0]     fifo_word_d [DEPTH];
    logic            protocol_err_q, protocol_err_d;

    logic [SumW-1:0] credit_used;
    logic [63:0]     redirect_base;
    logic            req_fire;
    logic            rsp_live;
    logic            rsp_stray;
    logic            push;
    logic            pop;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign redirect_base = {redirect_pc[63:2], 2'b00};

    // Outstanding requests plus buffered words never exceed DEPTH, so a push always fits.
    always_comb begin
        credit_used    = SumW'(out_cnt_q) + SumW'(occ_q);
        imem_req_valid = !rst && !redirect_valid && (credit_used < SumW'(DEPTH));
        imem_req_addr  = req_pc_q;
        inst_valid     = (occ_q != '0);
        inst           = inst_valid ? fifo_word_q[rd_ptr_q] : '0;
        inst_pc        = inst_valid ? fifo_pc_q[rd_ptr_q] : RESET_PC;
        protocol_err   = protocol_err_q;
    end

    always_comb begin
        req_fire  = imem_req_valid && imem_req_ready;
        rsp_live  = imem_rsp_valid && (out_cnt_q != '0);
        rsp_stray = imem_rsp_valid && (out_cnt_q == '0);
        push      = rsp_live && (drop_cnt_q == '0) && !redirect_valid;
        pop       = inst_valid && inst_ready && !redirect_valid;
    end

    always_comb begin
        req_pc_d       = req_pc_q;
        rsp_pc_d       = rsp_pc_q;
        drop_cnt_d     = drop_cnt_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fifo_pc_d      = fifo_pc_q;
        fifo_word_d    = fifo_word_q;
        protocol_err_d = protocol_err_q || rsp_stray;

        if (req_fire) begin
            req_pc_d = req_pc_q + 64'd4;
        end
        out_cnt_d = out_cnt_q + CntW'(req_fire) - CntW'(rsp_live);

        if (rsp_live && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end
        if (push) begin
            fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
            fifo_word_d[wr_ptr_q] = imem_rsp_data;
            wr_ptr_d              = wr_ptr_q + PtrW'(1);
            rsp_pc_d              = rsp_pc_q + 64'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        occ_d = occ_q + CntW'(push) - CntW'(pop);

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_valid) begin
            req_pc_d   = redirect_base;
            rsp_pc_d   = redirect_base;
            drop_cnt_d = out_cnt_q - CntW'(rsp_live);
            occ_d      = '0;
            rd_ptr_d   = wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q       <= RESET_PC;
            rsp_pc_q       <= RESET_PC;
            out_cnt_q      <= '0;
            drop_cnt_q     <= '0;
            occ_q          <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            req_pc_q       <= req_pc_d;
            rsp_pc_q       <= rsp_pc_d;
            out_cnt_q      <= out_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            occ_q          <= occ_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_word_q <= fifo_word_d;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a fixed-latency in-order instruction memory model.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        protocol_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_acc    = 0;
    bit rsp_is_mem = 1'b0;
    logic [63:0] q_addr [$];
    int          q_due  [$];
    logic [63:0] exp_pc;
    int          n;

    inst_fetch_unit #(
        .RESET_PC(64'h1000),
        .DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the memory answers each accepted request exactly lat edges later.
    task automatic tick();
        logic        fire;
        logic        rsp_was;
        logic        rst_was;
        logic [63:0] a;
        #1;
        fire    = imem_req_valid && imem_req_ready;
        a       = imem_req_addr;
        rsp_was = imem_rsp_valid && rsp_is_mem;
        rst_was = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) n_acc++;
        if (rst_was) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (rsp_was && q_addr.size() > 0) begin
                q_addr.delete(0);
                q_due.delete(0);
            end
            if (fire) begin
                q_addr.push_back(a);
                q_due.push_back(cyc + lat);
            end
        end
        rsp_is_mem     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (q_addr.size() > 0 && q_due[0] == cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(q_addr[0]);
            rsp_is_mem     = 1'b1;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_req_addr"}, imem_req_addr, 64'h1000);
        check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        check({tag, "_inst"}, 64'(inst), 64'd0);
        check({tag, "_inst_pc"}, inst_pc, 64'h1000);
        check({tag, "_perr"}, 64'(protocol_err), 64'd0);
    endtask

    task automatic check_stream(input string tag, input logic [63:0] start, input int count);
        logic [63:0] pc;
        pc = start;
        for (int i = 0; i < count; i++) begin
            check({tag, "_valid"}, 64'(inst_valid), 64'd1);
            check({tag, "_pc"}, inst_pc, pc);
            check({tag, "_word"}, 64'(inst), 64'(word_of(pc)));
            pc = pc + 64'd4;
            tick();
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;

        // Reset state and streaming start-up with 1-cycle memory.
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b0;
        #1;
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        check("first_req_addr", imem_req_addr, 64'h1000);
        tick();
        check("fill_inst_valid", 64'(inst_valid), 64'd0);
        check("second_req_addr", imem_req_addr, 64'h1004);
        tick();
        check_stream("stream", 64'h1000, 6);

        // Stalled decoder: exactly DEPTH requests, then stray response on an idle port.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        inst_ready = 1'b0;
        n_acc      = 0;
        repeat (10) tick();
        check("full_accepts", 64'(n_acc), 64'd4);
        check("full_req_valid", 64'(imem_req_valid), 64'd0);
        check("full_req_addr", imem_req_addr, 64'h1010);
        check("full_inst_valid", 64'(inst_valid), 64'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        rsp_is_mem     = 1'b0;
        tick();
        check("stray_perr", 64'(protocol_err), 64'd1);
        check("stray_head_pc", inst_pc, 64'h1000);
        inst_ready = 1'b1;
        check_stream("drain", 64'h1000, 8);
        check("perr_sticky", 64'(protocol_err), 64'd1);

        // Reset with a full FIFO.
        inst_ready = 1'b0;
        repeat (8) tick();
        check("refill_req_valid", 64'(imem_req_valid), 64'd0);
        check("refill_inst_valid", 64'(inst_valid), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst1");
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
        check("post_rst_req_addr", imem_req_addr, 64'h1000);

        // Redirect coinciding with a response and a pop: one outstanding, nothing to drop.
        repeat (5) tick();
        check("pre_redir_valid", 64'(inst_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3001;
        #1;
        check("redir_req_suppressed", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_flush", 64'(inst_valid), 64'd0);
        check("redir_req_valid", 64'(imem_req_valid), 64'd1);
        check("redir_req_addr", imem_req_addr, 64'h3000);
        check("redir_no_perr", 64'(protocol_err), 64'd0);
        tick();
        check("redir_r1_valid", 64'(inst_valid), 64'd0);
        tick();
        check_stream("redir_stream", 64'h3000, 3);

        // 3-cycle memory, redirect with three in flight: all three stale words dropped.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 3;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        #1;
        check("lat3_redir_req_suppressed", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("lat3_flush", 64'(inst_valid), 64'd0);
        check("lat3_req_addr", imem_req_addr, 64'h2000);
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        check("lat3_wait_cycles", 64'(n), 64'd4);
        check("lat3_pc", inst_pc, 64'h2000);
        check("lat3_word", 64'(inst), 64'(word_of(64'h2000)));
        check("lat3_no_perr", 64'(protocol_err), 64'd0);
        tick();
        check("lat3_next_pc", inst_pc, 64'h2004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
